// File: rtl/shift_sin_pout.sv
// Serial-in, parallel-out byte receiver with a one-deep holding register.
// Define SHIFT_SIN_POUT_OVERRUN_EN to add the sticky overrun flag output.
module shift_sin_pout #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sin,
    input  logic       sen,
    input  logic       sclr,
    input  logic       dack,
    output logic [7:0] dout,
    output logic       dready,
    output logic [2:0] bitcnt
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    logic [7:0] sr;
    logic [2:0] cnt;
    logic [7:0] shifted;
    logic       complete;

    // Shift direction decides whether the first bit ends up in dout[7] or dout[0].
    assign shifted  = MSB_FIRST ? {sr[6:0], sin} : {sin, sr[7:1]};
    assign complete = sen && !sclr && (cnt == 3'd7);
    assign bitcnt   = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= 8'h00;
            cnt <= 3'd0;
        end else if (sclr) begin
            sr  <= 8'h00;
            cnt <= 3'd0;
        end else if (sen) begin
            sr  <= shifted;
            cnt <= cnt + 3'd1;
        end
    end

    // dready/dack: dout is offered while dready=1 and is taken on any edge
    // with dack=1; a completing byte always replaces the held one, even on
    // the acknowledging edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout   <= 8'h00;
            dready <= 1'b0;
        end else if (complete) begin
            dout   <= shifted;
            dready <= 1'b1;
        end else if (dack && dready) begin
            dready <= 1'b0;
        end
    end

`ifdef SHIFT_SIN_POUT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            overrun <= 1'b0;
        end else if (complete && dready && !dack) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_sin_pout.sv
// Bench for shift_sin_pout: MSB-first and LSB-first instances share stimulus;
// expected bytes are queued when a byte is driven and popped on completion.
module tb_shift_sin_pout;

    logic       clk;
    logic       reset;
    logic       sin;
    logic       sen;
    logic       sclr;
    logic       dack;
    logic [7:0] dout_m, dout_l;
    logic       dready_m, dready_l;
    logic [2:0] bitcnt_m, bitcnt_l;
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
    logic       overrun_m, overrun_l;
`endif

    logic [7:0] exp_q[$];
    logic [7:0] exp_lsb_q[$];
    logic [7:0] held_m, held_l;
    logic       exp_dready;
    int         n_checks;
    int         n_pass;

    shift_sin_pout #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .sin(sin), .sen(sen), .sclr(sclr), .dack(dack),
        .dout(dout_m), .dready(dready_m), .bitcnt(bitcnt_m)
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        , .overrun(overrun_m)
`endif
    );

    shift_sin_pout #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .sin(sin), .sen(sen), .sclr(sclr), .dack(dack),
        .dout(dout_l), .dready(dready_l), .bitcnt(bitcnt_l)
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        , .overrun(overrun_l)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Shifts bits first..first+n-1 of seq (seq[7] is sent first). Starts and ends at a negedge.
    task automatic shift_bits(input logic [7:0] seq, input int first, input int n, input bit ack_last);
        for (int i = 0; i < n; i++) begin
            int k;
            logic [2:0] e;
            k = first + i;
            e = 3'(k % 8);
            n_checks++;
            if (bitcnt_m !== e || bitcnt_l !== e)
                $display("FAIL bitcnt: got %0d/%0d expected %0d", bitcnt_m, bitcnt_l, e);
            else
                n_pass++;
            sin  = seq[7-k];
            sen  = 1'b1;
            dack = ack_last && (i == n - 1);
            @(negedge clk);
        end
        sen  = 1'b0;
        dack = 1'b0;
    endtask

    task automatic check_complete();
        logic [7:0] em, el;
        n_checks++;
        if (exp_q.size() == 0 || exp_lsb_q.size() == 0) begin
            $display("FAIL scoreboard: got empty queue expected pending byte");
            return;
        end
        em = exp_q.pop_front();
        el = exp_lsb_q.pop_front();
        if (dout_m !== em || dout_l !== el)
            $display("FAIL dout: got %h/%h expected %h/%h", dout_m, dout_l, em, el);
        else
            n_pass++;
        n_checks++;
        if (dready_m !== 1'b1 || dready_l !== 1'b1 || bitcnt_m !== 3'd0 || bitcnt_l !== 3'd0)
            $display("FAIL complete_flags: got dready %b/%b bitcnt %0d/%0d expected 1/1 0/0",
                     dready_m, dready_l, bitcnt_m, bitcnt_l);
        else
            n_pass++;
        held_m     = em;
        held_l     = el;
        exp_dready = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] seq, input bit ack_last);
        exp_q.push_back(seq);
        exp_lsb_q.push_back(rev8(seq));
        shift_bits(seq, 0, 8, ack_last);
        check_complete();
    endtask

    task automatic ack_pulse();
        dack = 1'b1;
        @(negedge clk);
        dack = 1'b0;
        exp_dready = 1'b0;
        n_checks++;
        if (dready_m !== 1'b0 || dready_l !== 1'b0 || dout_m !== held_m || dout_l !== held_l)
            $display("FAIL ack: got dready %b/%b dout %h/%h expected 0/0 %h/%h",
                     dready_m, dready_l, dout_m, dout_l, held_m, held_l);
        else
            n_pass++;
    endtask

    task automatic sclr_pulse();
        sclr = 1'b1;
        sen  = 1'b1;
        sin  = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        sen  = 1'b0;
        n_checks++;
        if (bitcnt_m !== 3'd0 || bitcnt_l !== 3'd0 || dready_m !== exp_dready || dready_l !== exp_dready ||
            dout_m !== held_m || dout_l !== held_l)
            $display("FAIL sclr: got bitcnt %0d/%0d dready %b/%b dout %h/%h expected 0 %b %h/%h",
                     bitcnt_m, bitcnt_l, dready_m, dready_l, dout_m, dout_l, exp_dready, held_m, held_l);
        else
            n_pass++;
    endtask

    task automatic check_reset_state(input string name);
        n_checks++;
        if (dout_m !== 8'h00 || dout_l !== 8'h00 || dready_m !== 1'b0 || dready_l !== 1'b0 ||
            bitcnt_m !== 3'd0 || bitcnt_l !== 3'd0)
            $display("FAIL %s: got dout %h/%h dready %b/%b bitcnt %0d/%0d expected all zero",
                     name, dout_m, dout_l, dready_m, dready_l, bitcnt_m, bitcnt_l);
        else
            n_pass++;
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        n_checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0)
            $display("FAIL %s_overrun: got %b/%b expected 0", name, overrun_m, overrun_l);
        else
            n_pass++;
`endif
        held_m     = 8'h00;
        held_l     = 8'h00;
        exp_dready = 1'b0;
        exp_q.delete();
        exp_lsb_q.delete();
    endtask

    // Reset asserted while sen, sin and dack are active: reset must win.
    task automatic test_reset();
        reset = 1'b1;
        sen   = 1'b1;
        sin   = 1'b1;
        dack  = 1'b1;
        sclr  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sen   = 1'b0;
        dack  = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_basic();
        send_byte(8'hA5, 1'b0);
        ack_pulse();
        ack_pulse();                 // dack with dready=0 is ignored
        send_byte(8'hC0, 1'b0);      // LSB-first instance sees 8'h03
        ack_pulse();
    endtask

    task automatic test_hold();
        exp_q.push_back(8'h96);
        exp_lsb_q.push_back(rev8(8'h96));
        shift_bits(8'h96, 0, 3, 1'b0);
        repeat (2) begin
            sin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        shift_bits(8'h96, 3, 5, 1'b0);
        check_complete();
        ack_pulse();
    endtask

    task automatic test_overrun();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        n_checks++;
        if (overrun_m !== 1'b1 || overrun_l !== 1'b1)
            $display("FAIL overrun_set: got %b/%b expected 1", overrun_m, overrun_l);
        else
            n_pass++;
`endif
        ack_pulse();
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        n_checks++;
        if (overrun_m !== 1'b1 || overrun_l !== 1'b1)
            $display("FAIL overrun_sticky: got %b/%b expected 1", overrun_m, overrun_l);
        else
            n_pass++;
`endif
        sclr_pulse();
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        n_checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0)
            $display("FAIL overrun_clear: got %b/%b expected 0", overrun_m, overrun_l);
        else
            n_pass++;
`endif
    endtask

    task automatic test_sclr();
        shift_bits(8'hFF, 0, 4, 1'b0);
        sclr_pulse();
        send_byte(8'h81, 1'b0);
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h5A, 1'b0);
        send_byte(8'h7E, 1'b1);      // dack on the completing edge: new byte wins
`ifdef SHIFT_SIN_POUT_OVERRUN_EN
        n_checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0)
            $display("FAIL b2b_overrun: got %b/%b expected 0", overrun_m, overrun_l);
        else
            n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        shift_bits(8'h00, 0, 5, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset_mid");
        send_byte(8'hFF, 1'b0);
        ack_pulse();
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            send_byte(v, 1'b0);
            if ($urandom_range(0, 1) == 1) ack_pulse();
            else send_byte(8'($urandom_range(0, 255)), 1'b1);
        end
        ack_pulse();
        sclr_pulse();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        sin   = 1'b0;
        sen   = 1'b0;
        sclr  = 1'b0;
        dack  = 1'b0;
        held_m = 8'h00;
        held_l = 8'h00;
        exp_dready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_sclr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
